// File: rtl/pipeline_trace_buffer_if.sv
// Debug-tap, trigger-configuration and readout signals of the pipeline trace buffer.
// Record width grows by a 16-bit timestamp when TRACE_TIMESTAMP_EN is defined.
interface pipeline_trace_buffer_if #(
    parameter int DATA_W = 16,
    parameter int INS_W  = 32,
    parameter int DEPTH  = 64
);
    localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif
    localparam int ENTRY_W = INS_W + 3*DATA_W + TS_W;

    logic [INS_W-1:0]   ins;
    logic [DATA_W-1:0]  current_address;
    logic [DATA_W-1:0]  ans_ex;
    logic [DATA_W-1:0]  ans_wb;
    logic               stall;
    logic               arm;
    logic [1:0]         trig_mode;
    logic [DATA_W-1:0]  trig_addr;
    logic [5:0]         trig_op;
    logic               trig_ext;
    logic [AW:0]        post_count;
    logic               rd_req;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_last;
    logic [1:0]         state;
    logic               triggered;
    logic [AW:0]        count;

    modport master (
        output ins, current_address, ans_ex, ans_wb, stall, arm,
               trig_mode, trig_addr, trig_op, trig_ext, post_count, rd_req,
        input  rd_valid, rd_data, rd_last, state, triggered, count
    );
    modport slave (
        input  ins, current_address, ans_ex, ans_wb, stall, arm,
               trig_mode, trig_addr, trig_op, trig_ext, post_count, rd_req,
        output rd_valid, rd_data, rd_last, state, triggered, count
    );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Circular trace capture of the MIPS debug taps with trigger/post-count stop and oldest-first drain.
// Optional TRACE_TIMESTAMP_EN appends a free-running 16-bit cycle stamp to every record.
module pipeline_trace_buffer #(
    parameter int DATA_W = 16,
    parameter int INS_W  = 32,
    parameter int DEPTH  = 64
) (
    input logic                    clk,
    input logic                    reset,
    pipeline_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif
    localparam int ENTRY_W = INS_W + 3*DATA_W + TS_W;
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

    state_t             r_state, w_state_nxt;
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr, w_wr_ptr_inc;
    logic [AW:0]        r_count, w_count_inc, r_rd_cnt, r_remaining;
    logic               r_triggered, r_rd_valid, r_rd_last;
    logic [ENTRY_W-1:0] r_rd_data, w_entry;
    logic               w_qual, w_hit, w_we, w_rd_fire, w_rd_final, w_enter_done;

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] r_ts;
    always_ff @(posedge clk) begin
        if (reset) r_ts <= '0;
        else       r_ts <= r_ts + 16'd1;
    end
    assign w_entry = {bus.ins, bus.current_address, bus.ans_ex, bus.ans_wb, r_ts};
`else
    assign w_entry = {bus.ins, bus.current_address, bus.ans_ex, bus.ans_wb};
`endif

    assign w_qual = !bus.stall;

    always_comb begin
        w_hit = 1'b0;
        unique case (bus.trig_mode)
            2'b00:   w_hit = (bus.current_address == bus.trig_addr);
            2'b01:   w_hit = (bus.ins[INS_W-1 -: 6] == bus.trig_op);
            2'b10:   w_hit = bus.trig_ext;
            default: w_hit = 1'b1;
        endcase
    end

    // arm takes priority over everything except reset, so it suppresses writes and reads
    assign w_we         = !reset && !bus.arm && w_qual && (r_state == S_ARMED || r_state == S_POST);
    assign w_rd_fire    = !bus.arm && (r_state == S_DONE) && bus.rd_req;
    assign w_rd_final   = ((r_rd_cnt + ONE) == r_count);
    assign w_wr_ptr_inc = r_wr_ptr + AW'(1);
    assign w_count_inc  = (r_count == FULL) ? r_count : r_count + ONE;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_done = 1'b0;
        if (bus.arm) begin
            w_state_nxt = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED: if (w_qual && w_hit) begin
                    if (bus.post_count == '0) begin
                        w_state_nxt  = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_nxt = S_POST;
                    end
                end
                S_POST: if (w_qual && r_remaining == ONE) begin
                    w_state_nxt  = S_DONE;
                    w_enter_done = 1'b1;
                end
                S_DONE: if (w_rd_fire && w_rd_final) w_state_nxt = S_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_rd_cnt    <= '0;
            r_triggered <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_last  <= w_rd_fire && w_rd_final;
            if (w_rd_fire) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_cnt  <= r_rd_cnt + ONE;
            end
            if (bus.arm) begin
                r_wr_ptr    <= '0;
                r_count     <= '0;
                r_remaining <= '0;
                r_triggered <= 1'b0;
            end else if (w_we) begin
                r_wr_ptr <= w_wr_ptr_inc;
                r_count  <= w_count_inc;
                if (r_state == S_ARMED && w_hit) begin
                    r_remaining <= bus.post_count;
                    r_triggered <= 1'b1;
                end else if (r_state == S_POST) begin
                    r_remaining <= r_remaining - ONE;
                end
            end
            // once the buffer has wrapped, the slot about to be overwritten is the oldest
            if (w_enter_done) begin
                r_rd_ptr <= (w_count_inc == FULL) ? w_wr_ptr_inc : '0;
                r_rd_cnt <= '0;
            end
        end
    end

    assign bus.state     = r_state;
    assign bus.triggered = r_triggered;
    assign bus.count     = r_count;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_last   = r_rd_last;
    assign bus.rd_data   = r_rd_data;
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed plus randomized bench for pipeline_trace_buffer against a queue-based record model.
module tb_pipeline_trace_buffer;
    localparam int DATA_W = 16;
    localparam int INS_W  = 32;
    localparam int DEPTH  = 8;
    localparam int AW     = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif
    localparam int ENTRY_W = INS_W + 3*DATA_W + TS_W;
    localparam int PC_LSB  = 2*DATA_W + TS_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_trace_buffer_if #(.DATA_W(DATA_W), .INS_W(INS_W), .DEPTH(DEPTH)) bus ();
    pipeline_trace_buffer #(.DATA_W(DATA_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));

    int total = 0;
    int bad   = 0;

    // reference model: the record is simply the last DEPTH qualified snapshots
    logic [ENTRY_W-1:0] m_q[$];
    int                 m_state = 0;
    int                 m_rem   = 0;
    int                 m_idx   = 0;
    bit                 m_trig  = 0;
    bit                 m_rv    = 0;
    bit                 m_rl    = 0;
    logic [ENTRY_W-1:0] m_rd    = '0;
    logic [15:0]        m_ts    = '0;

    logic [15:0] d_pc    = '0;
    bit          rnd_ins = 0;
    int          rd_pcs[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [ENTRY_W-1:0] e;
        bit hit;
        case (bus.trig_mode)
            2'b00:   hit = (bus.current_address == bus.trig_addr);
            2'b01:   hit = (bus.ins[31:26] == bus.trig_op);
            2'b10:   hit = bus.trig_ext;
            default: hit = 1'b1;
        endcase
`ifdef TRACE_TIMESTAMP_EN
        e = {bus.ins, bus.current_address, bus.ans_ex, bus.ans_wb, m_ts};
`else
        e = {bus.ins, bus.current_address, bus.ans_ex, bus.ans_wb};
`endif
        if (reset) begin
            m_state = 0; m_q.delete(); m_trig = 0; m_rv = 0; m_rl = 0; m_rd = '0;
        end else begin
            m_rv = 0; m_rl = 0;
            if (bus.arm) begin
                m_state = 1; m_q.delete(); m_trig = 0;
            end else if ((m_state == 1 || m_state == 2) && !bus.stall) begin
                m_q.push_back(e);
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
                if (m_state == 1) begin
                    if (hit) begin
                        m_trig = 1; m_rem = int'(bus.post_count); m_idx = 0;
                        m_state = (m_rem == 0) ? 3 : 2;
                    end
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin m_state = 3; m_idx = 0; end
                end
            end else if (m_state == 3 && bus.rd_req) begin
                m_rd = m_q[m_idx]; m_rv = 1;
                m_rl = (m_idx == m_q.size() - 1);
                m_idx++;
                if (m_rl) m_state = 0;
            end
        end
        m_ts = reset ? 16'd0 : m_ts + 16'd1;
    endtask

    task automatic cyc(input bit arm, input bit stall, input bit rdreq, input bit rst);
        @(negedge clk);
        reset = rst; bus.arm = arm; bus.stall = stall; bus.rd_req = rdreq;
        bus.current_address = d_pc;
        bus.ins    = rnd_ins ? $urandom : {(d_pc == 16'h0005) ? 6'h05 : 6'h00, 26'h0};
        bus.ans_ex = 16'($urandom);
        bus.ans_wb = 16'($urandom);
        model_step();
        d_pc = d_pc + 16'd1;
        @(posedge clk); #1;
        chk("state", bus.state, m_state);
        chk("count", bus.count, m_q.size());
        chk("triggered", bus.triggered, m_trig);
        chk("rd_valid", bus.rd_valid, m_rv);
        chk("rd_last", bus.rd_last, m_rl);
        chk("rd_data", bus.rd_data, m_rd);
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (m_state != target && n < budget) begin cyc(0, 0, 0, 0); n++; end
        chk(tag, bus.state, target);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rd_pcs.delete();
        while (m_state == 3 && n < 20) begin
            cyc(0, 0, 1, 0);
            if (bus.rd_valid) rd_pcs.push_back(int'(bus.rd_data[PC_LSB +: 16]));
            n++;
        end
        chk(tag, bus.state, 0);
    endtask

    task automatic setup(input logic [1:0] mode, input logic [15:0] addr, input int post);
        bus.trig_mode = mode; bus.trig_addr = addr; bus.trig_op = 6'h05;
        bus.trig_ext = 1'b0; bus.post_count = (AW+1)'(post);
    endtask

    initial begin
        reset = 1'b1;
        bus.arm = 0; bus.stall = 0; bus.rd_req = 0; bus.ins = '0; bus.current_address = '0;
        bus.ans_ex = '0; bus.ans_wb = '0;
        setup(2'b00, 16'h0010, 3);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 1, 1);
        chk("rst_state", bus.state, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_rd_data", bus.rd_data, 0);

        // 1: PC trigger with wrap, 8 oldest-first reads 0x0C..0x13
        d_pc = 16'hFFFF; cyc(1, 0, 0, 0);
        run_until(3, 40, "t1_done");
        chk("t1_count", bus.count, 8);
        drain("t1_idle");
        chk("t1_nreads", rd_pcs.size(), 8);
        foreach (rd_pcs[i]) chk("t1_pc", rd_pcs[i], 16'h000C + i);

        // 2: early trigger, no wrap
        setup(2'b00, 16'h0002, 1);
        d_pc = 16'hFFFF; cyc(1, 0, 0, 0);
        run_until(3, 20, "t2_done");
        chk("t2_count", bus.count, 4);
        drain("t2_idle");
        chk("t2_nreads", rd_pcs.size(), 4);
        foreach (rd_pcs[i]) chk("t2_pc", rd_pcs[i], i);

        // 3: opcode trigger at PC 5, stalls in POST are not recorded
        setup(2'b01, 16'h0000, 2);
        d_pc = 16'hFFFF; cyc(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
        chk("t3_trig", bus.triggered, 1);
        chk("t3_post", bus.state, 2);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        chk("t3_stall_state", bus.state, 2);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("t3_done", bus.state, 3);
        chk("t3_count", bus.count, 8);
        drain("t3_idle");
        chk("t3_nreads", rd_pcs.size(), 8);
        if (rd_pcs.size() == 8) begin
            chk("t3_pc5", rd_pcs[5], 5);
            chk("t3_pc6", rd_pcs[6], 8);
            chk("t3_pc7", rd_pcs[7], 9);
        end

        // 4: first-cycle trigger, post_count 0 gives a single entry
        setup(2'b11, 16'h0000, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t4_done", bus.state, 3);
        chk("t4_count", bus.count, 1);
        cyc(0, 0, 1, 0);
        chk("t4_valid", bus.rd_valid, 1);
        chk("t4_last", bus.rd_last, 1);
        chk("t4_idle", bus.state, 0);

        // 5: reset mid-readout
        setup(2'b00, 16'h0010, 3);
        d_pc = 16'hFFFF; cyc(1, 0, 0, 0);
        run_until(3, 40, "t5_done");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        chk("t5_state", bus.state, 0);
        chk("t5_valid", bus.rd_valid, 0);
        chk("t5_count", bus.count, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0);
            chk("t5_noread", bus.rd_valid, 0);
        end

        // 6: re-arm during POST, then a fresh capture
        setup(2'b00, 16'h0004, 5);
        d_pc = 16'hFFFF; cyc(1, 0, 0, 0);
        run_until(2, 20, "t6_post");
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t6_trig", bus.triggered, 0);
        chk("t6_count", bus.count, 0);
        chk("t6_state", bus.state, 1);
        setup(2'b00, d_pc + 16'd3, 2);
        run_until(3, 20, "t6_done");
        chk("t6_count2", bus.count, 6);
        drain("t6_idle");
        chk("t6_nreads", rd_pcs.size(), 6);

        // randomized traffic against the model
        rnd_ins = 1;
        for (int i = 0; i < 600; i++) begin
            bit a;
            a = ($urandom_range(0, 99) < 4) || (m_state == 0 && $urandom_range(0, 9) == 0);
            if (a) setup(2'(($urandom_range(0, 3))), d_pc + 16'($urandom_range(0, 20)),
                         int'($urandom_range(0, 2*DEPTH - 1)));
            bus.trig_ext = ($urandom_range(0, 9) == 0);
            cyc(a, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
Parametrised on-chip trace capture unit for the 16-bit MIPS pipeline debug path. Records a per-cycle snapshot of ins, current_address, ans_ex and ans_wb into a circular buffer. Capture stops after a programmable trigger plus a programmable post-trigger count. The record is then drained oldest-first over a request/valid handshake. It sits beside the core top level and taps the same debug signals the top level already exports.

Parameters:
DATA_W, 16, width of the address and data taps
INS_W, 32, width of the instruction tap
DEPTH, 64, buffer entries (power of 2, at least 4); AW = clog2(DEPTH)
ENTRY_W, INS_W+3*DATA_W, record width (derived; grows with the optional feature)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
ins  in  INS_W  instruction tap (opcode is ins[31:26])
current_address  in  DATA_W  PC tap
ans_ex  in  DATA_W  EX result tap
ans_wb  in  DATA_W  WB result tap
stall  in  1  1 = cycle not qualified (no write, no trigger evaluation)
arm  in  1  1-cycle pulse: start or restart capture
trig_mode  in  2  00 PC==trig_addr, 01 ins[31:26]==trig_op, 10 trig_ext==1, 11 first qualified cycle
trig_addr  in  DATA_W  PC match value
trig_op  in  6  opcode match value
trig_ext  in  1  external trigger (e.g. interrupt)
post_count  in  AW+1  qualified entries to record after the trigger entry
rd_req  in  1  request next entry (DONE state only)
rd_valid  out  1  1-cycle pulse, rd_data valid
rd_data  out  ENTRY_W  {ins, current_address, ans_ex, ans_wb}, MSB first
rd_last  out  1  high with rd_valid on the final entry
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
triggered  out  1  set the cycle after the trigger fires; cleared on arm or reset
count  out  AW+1  valid entries, saturates at DEPTH

Behaviour:
- Reset: state=IDLE; wr_ptr, rd_ptr, count, remaining = 0; rd_valid, rd_last, rd_data, triggered = 0. Buffer RAM is not reset. Reset mid-capture or mid-readout aborts immediately.
- Qualified cycle: stall==0. Only qualified cycles write an entry, evaluate the trigger, or decrement remaining.
- IDLE: no capture. arm → ARMED with wr_ptr=0, count=0, triggered=0. Trigger inputs are ignored.
- ARMED: each qualified cycle writes the entry at wr_ptr, then wr_ptr = wr_ptr+1 mod DEPTH and count = min(count+1, DEPTH).
- Trigger in ARMED: condition is evaluated on the same-cycle inputs, and that cycle's entry is always written. Then remaining=post_count; next state is POST, or DONE if post_count==0.
- POST: each qualified write decrements remaining. The write that brings remaining to 0 moves the block to DONE. If post_count >= DEPTH, pre-trigger entries are overwritten; retained entries = min(total, DEPTH).
- Entering DONE: rd_ptr = oldest entry, i.e. (count==DEPTH) ? wr_ptr : 0. count is at least 1.
- DONE, rd_req=1 and no read in flight: rd_valid=1 on the next cycle with registered RAM data (1-cycle latency).
  - rd_req while rd_valid=1 is accepted; back-to-back reads give one entry per cycle.
  - rd_ptr wraps mod DEPTH.
  - rd_last=1 on entry number count.
  - After the last entry is returned, state → IDLE. rd_req is ignored from that cycle on.
- rd_req in IDLE, ARMED or POST: ignored, no rd_valid.
- arm in ARMED, POST or DONE: restart as from IDLE. Any pending read is dropped, and rd_valid is 0 the next cycle.
- arm and trigger in the same IDLE cycle: arm only, no entry written.
- Simultaneous reset and arm: reset wins.

Optional Feature:
TRACE_TIMESTAMP_EN
- Defined: adds a 16-bit free-running cycle counter that resets to 0, increments every clk including stalled cycles, and wraps at 0xFFFF. The counter is appended as the LSBs of every entry, so ENTRY_W = INS_W+3*DATA_W+16.
- Undefined: no counter; ENTRY_W = INS_W+3*DATA_W.

Test Plan:
1. DEPTH=8, PC increments 0x0000 upward every cycle, stall=0, trig_mode=00, trig_addr=0x0010, post_count=3, arm → DONE after PC 0x0013 is written; 8 reads return PC 0x000C..0x0013, with rd_last on the 8th; state=IDLE afterwards.
2. Same setup, trig_addr=0x0002, post_count=1 → count=4; reads return PC 0x0000..0x0003 oldest-first.
3. trig_mode=01, trig_op=6'b000101, ins[31:26]=000101 at PC 0x0005; stall=1 for 2 cycles during POST, post_count=2 → stalled PCs absent, exactly 2 post entries recorded, triggered=1 from the cycle after PC 0x0005.
4. trig_mode=11, post_count=0, arm → DONE after 1 qualified cycle, count=1; one read gives rd_valid and rd_last together.
5. Reset asserted after 3 of 8 reads → next cycle state=IDLE, rd_valid=0, count=0; further rd_req produces no rd_valid.
6. arm pulsed in POST → triggered=0, count=0, state=ARMED; a new trigger produces a fresh, correct record.
